// File: rtl/inst_buffer.sv
// Purpose     : fetch-to-decode instruction queue of aligned two-instruction packets.
// Latency     : 1 cycle from push to presentation (0 cycles when empty with INST_BUF_BYPASS_EN).
// Backpressure: fetch_rdy drops when all DEPTH entries are full (no pop-through); decode_rdy pops.
//
// Optional feature macro: INST_BUF_BYPASS_EN (empty-buffer fetch->decode bypass).
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   flush                         synchronous discard of all buffered packets
//   fetch_val / fetch_rdy         fetch-side handshake
//   fetch_pc, fetch_inst0/1       incoming packet (inst1 lives at fetch_pc+4)
//   decode_rdy / inst_val         decode-side handshake
//   inst0_pc, inst1_pc, inst0/1   presented packet; all zero when inst_val=0
//   buf_count                     occupied entries, 0..DEPTH
module inst_buffer #(
  parameter int DEPTH         = 8,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_INST_BITS = 32,
  localparam int PTR_BITS     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_val,
  output logic                     fetch_rdy,
  input  logic [CPU_ADDR_BITS-1:0] fetch_pc,
  input  logic [CPU_INST_BITS-1:0] fetch_inst0,
  input  logic [CPU_INST_BITS-1:0] fetch_inst1,
  input  logic                     decode_rdy,
  output logic                     inst_val,
  output logic [CPU_ADDR_BITS-1:0] inst0_pc,
  output logic [CPU_ADDR_BITS-1:0] inst1_pc,
  output logic [CPU_INST_BITS-1:0] inst0,
  output logic [CPU_INST_BITS-1:0] inst1,
  output logic [PTR_BITS:0]        buf_count
);

  // DEPTH must be a power of two: pointers wrap by natural overflow.
  localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS + 1)'(DEPTH);

  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] pc;
    logic [CPU_INST_BITS-1:0] inst0;
    logic [CPU_INST_BITS-1:0] inst1;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [PTR_BITS-1:0] head_q;
  logic [PTR_BITS-1:0] tail_q;
  logic [PTR_BITS:0]   count_q;

  logic   empty;
  logic   push;
  logic   pop;
  entry_t fetch_ent;
  entry_t pres_ent;

  assign empty     = (count_q == '0);
  assign fetch_rdy = (count_q != FULL_CNT);
  assign buf_count = count_q;

  assign fetch_ent.pc    = fetch_pc;
  assign fetch_ent.inst0 = fetch_inst0;
  assign fetch_ent.inst1 = fetch_inst1;

`ifdef INST_BUF_BYPASS_EN
  // When empty, the incoming packet is shown to decode straight away. If decode
  // takes it in the same cycle it never touches the array.
  logic bypass;
  assign bypass   = empty && fetch_val && !flush && !rst;
  assign inst_val = !empty || bypass;
  assign pop      = !empty && decode_rdy;
  assign push     = fetch_val && fetch_rdy && !(bypass && decode_rdy);
  assign pres_ent = empty ? fetch_ent : mem[head_q];
`else
  assign inst_val = !empty;
  assign pop      = inst_val && decode_rdy;
  assign push     = fetch_val && fetch_rdy;
  assign pres_ent = mem[head_q];
`endif

  // Data outputs are forced to zero whenever nothing valid is presented, so
  // stale array contents never leak to decode.
  always_comb begin
    inst0_pc = '0;
    inst1_pc = '0;
    inst0    = '0;
    inst1    = '0;
    if (inst_val) begin
      inst0_pc = pres_ent.pc;
      inst1_pc = pres_ent.pc + CPU_ADDR_BITS'(4);
      inst0    = pres_ent.inst0;
      inst1    = pres_ent.inst1;
    end
  end

  // Pointer and occupancy state. Reset and flush behave identically and win over
  // any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_BITS'(1);
      if (pop)  head_q <= head_q + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_BITS + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_BITS + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Array has no reset. A write that lands during flush/reset is harmless: the
  // pointers are cleared in the same edge, so the entry is never presented.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= fetch_ent;
  end

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int IW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          fetch_val;
  logic          fetch_rdy;
  logic [AW-1:0] fetch_pc;
  logic [IW-1:0] fetch_inst0;
  logic [IW-1:0] fetch_inst1;
  logic          decode_rdy;
  logic          inst_val;
  logic [AW-1:0] inst0_pc;
  logic [AW-1:0] inst1_pc;
  logic [IW-1:0] inst0;
  logic [IW-1:0] inst1;
  logic [$clog2(DEPTH):0] buf_count;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] i0;
    logic [IW-1:0] i1;
  } pkt_t;

  pkt_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic last_push;

  always #5 clk = ~clk;

  inst_buffer #(.DEPTH(DEPTH), .CPU_ADDR_BITS(AW), .CPU_INST_BITS(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_val(fetch_val), .fetch_rdy(fetch_rdy), .fetch_pc(fetch_pc),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
    .decode_rdy(decode_rdy), .inst_val(inst_val),
    .inst0_pc(inst0_pc), .inst1_pc(inst1_pc), .inst0(inst0), .inst1(inst1),
    .buf_count(buf_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; compare outputs against the
  // scoreboard mid-cycle, update the scoreboard, then advance past the edge.
  task automatic step();
    int            n;
    logic          byp;
    logic          exp_val;
    logic          pop;
    logic          push;
    logic [AW-1:0] pc4;
    pkt_t          p;
    #3;
    n   = sb.size();
    byp = 1'b0;
`ifdef INST_BUF_BYPASS_EN
    byp = (n == 0) && fetch_val && !flush && !rst;
`endif
    exp_val = (n != 0) || byp;
    check("buf_count", 64'(buf_count), 64'(n));
    check("fetch_rdy", 64'(fetch_rdy), 64'(n != DEPTH));
    check("inst_val", 64'(inst_val), 64'(exp_val));
    if (n != 0) begin
      pc4 = sb[0].pc + 32'd4;
      check("inst0_pc", 64'(inst0_pc), 64'(sb[0].pc));
      check("inst1_pc", 64'(inst1_pc), 64'(pc4));
      check("inst0", 64'(inst0), 64'(sb[0].i0));
      check("inst1", 64'(inst1), 64'(sb[0].i1));
    end else if (byp) begin
      pc4 = fetch_pc + 32'd4;
      check("byp_inst0_pc", 64'(inst0_pc), 64'(fetch_pc));
      check("byp_inst1_pc", 64'(inst1_pc), 64'(pc4));
      check("byp_inst0", 64'(inst0), 64'(fetch_inst0));
      check("byp_inst1", 64'(inst1), 64'(fetch_inst1));
    end else begin
      check("idle_pcs", {inst0_pc, inst1_pc}, 64'h0);
      check("idle_insts", {inst0, inst1}, 64'h0);
    end
    last_push = 1'b0;
    if (rst || flush) begin
      sb.delete();
    end else begin
      pop  = exp_val && decode_rdy;
      push = fetch_val && (n != DEPTH) && !(byp && decode_rdy);
      if (pop && n != 0) void'(sb.pop_front());
      if (push) begin
        p.pc = fetch_pc; p.i0 = fetch_inst0; p.i1 = fetch_inst1;
        sb.push_back(p);
      end
      last_push = push || (byp && decode_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic fv, input logic [AW-1:0] pc, input logic dr);
    fetch_val   = fv;
    fetch_pc    = pc;
    fetch_inst0 = pc ^ 32'h00500093;
    fetch_inst1 = ~pc ^ 32'h00a00113;
    decode_rdy  = dr;
    step();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      drv(1'b0, '0, 1'b1);
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'h0);
    drv(1'b0, '0, 1'b1);
  endtask

  initial begin
    int guard;
    rst = 1'b1; flush = 1'b0; fetch_val = 1'b0; decode_rdy = 1'b0;
    fetch_pc = '0; fetch_inst0 = '0; fetch_inst1 = '0;
    @(posedge clk); #1;
    step();                       // reset state, reset still asserted
    rst = 1'b0;
    step();

    // 1: single packet, consumed as soon as it is presented
    fetch_val = 1'b1; fetch_pc = 32'h1000;
    fetch_inst0 = 32'h00500093; fetch_inst1 = 32'h00a00113; decode_rdy = 1'b1;
    step();
    drain();

    // 2: fill to full, 9th held by fetch until space, then ordered drain
    for (int i = 0; i < 8; i++) drv(1'b1, 32'(i * 8), 1'b0);
    drv(1'b1, 32'h40, 1'b0);      // full: not accepted
    drv(1'b1, 32'h40, 1'b0);
    guard = 0;
    do begin
      drv(1'b1, 32'h40, 1'b1);
      guard++;
    end while (!last_push && guard < 20);
    if (!last_push) check("ninth_timeout", 64'(last_push), 64'h1);
    drain();

    // 3: pointer wrap with sustained push+pop
    for (int i = 0; i < 6; i++) drv(1'b1, 32'h100 + 32'(i * 8), 1'b0);
    for (int i = 0; i < 6; i++) drv(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) drv(1'b1, 32'h200 + 32'(i * 8), 1'b1);
    drain();

    // 4: flush while loaded, with push and pop requested
    for (int i = 0; i < 5; i++) drv(1'b1, 32'h300 + 32'(i * 8), 1'b0);
    flush = 1'b1;
    drv(1'b1, 32'h3F0, 1'b1);
    flush = 1'b0;
    drv(1'b0, '0, 1'b0);          // must be empty with fetch_rdy=1
    drv(1'b1, 32'h2000, 1'b0);
    drv(1'b0, '0, 1'b0);
    check("post_flush_first", 64'(inst0_pc), 64'h2000);
    drain();

    // 5: inst1_pc wrap at top of address space
    drv(1'b1, 32'hFFFFFFF8, 1'b0);
    drv(1'b1, 32'hFFFFFFFC, 1'b0);
    check("pc_top_a", 64'(inst1_pc), 64'hFFFFFFFC);
    drv(1'b0, '0, 1'b1);
    check("pc_top_b", 64'(inst1_pc), 64'h0);
    drain();

    // reset mid back-pressure leaves nothing behind
    for (int i = 0; i < 4; i++) drv(1'b1, 32'h500 + 32'(i * 8), 1'b0);
    rst = 1'b1;
    drv(1'b1, 32'h5F0, 1'b1);
    rst = 1'b0;
    drv(1'b1, 32'h600, 1'b0);
    drv(1'b0, '0, 1'b0);
    check("post_rst_first", 64'(inst0_pc), 64'h600);
    drain();

    // 6: empty-buffer presentation, consumed and not consumed
    drv(1'b1, 32'h700, 1'b1);
    drv(1'b0, '0, 1'b0);
    drv(1'b1, 32'h708, 1'b0);
    drv(1'b0, '0, 1'b0);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      flush = ($urandom_range(0, 40) == 0);
      drv(1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFFFFFC, 1'($urandom_range(0, 1)));
    end
    flush = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
